// File: rtl/stepped_counter_pkg.sv
// stepped_counter_pkg: shared encodings and CTRL field layout helpers for the
// stepped counter bank (limit modes, config addresses, field bit offsets).
package stepped_counter_pkg;

  // Limit behaviour of a channel; code 3 behaves like WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_BOUNCE   = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } mode_e;

  // Config register addresses; address 3 is reserved and ignored.
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DIV   = 2'd1;
  localparam logic [1:0] ADDR_VALUE = 2'd2;

  // CTRL layout: [0] en, then tsel, step, dir, mode packed upward.
  function automatic int unsigned ctrl_en_bit();
    return 0;
  endfunction

  function automatic int unsigned ctrl_tsel_lsb();
    return 1;
  endfunction

  function automatic int unsigned ctrl_step_lsb(int unsigned tsw);
    return tsw + 1;
  endfunction

  function automatic int unsigned ctrl_dir_bit(int unsigned tsw, int unsigned sw);
    return tsw + sw + 1;
  endfunction

  function automatic int unsigned ctrl_mode_lsb(int unsigned tsw, int unsigned sw);
    return tsw + sw + 2;
  endfunction

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/stepped_counter_ch.sv
// stepped_counter_ch: one counter channel -- config registers, strobe divider
// and limit-aware next-value logic.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   strobe_i            selected prescaler tap (already muxed by the top)
//   ctrl_we_i/div_we_i/val_we_i  per-register write strobes
//   wdata_i             config write data
//   tsel_o              current tap select, drives the top-level tap mux
//   ctr_o               counter value
//   tick_o, lim_o       one-cycle update / limit-event pulses
module stepped_counter_ch
  import stepped_counter_pkg::*;
#(
  parameter int unsigned CW   = 8,
  parameter int unsigned SW   = 4,
  parameter int unsigned TSW  = 3,
  parameter int unsigned DIVW = 8,
  parameter int unsigned WDW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            strobe_i,
  input  logic            ctrl_we_i,
  input  logic            div_we_i,
  input  logic            val_we_i,
  input  logic [WDW-1:0]  wdata_i,
  output logic [TSW-1:0]  tsel_o,
  output logic [CW-1:0]   ctr_o,
  output logic            tick_o,
  output logic            lim_o
);

  localparam int unsigned EN_BIT    = ctrl_en_bit();
  localparam int unsigned TSEL_LSB  = ctrl_tsel_lsb();
  localparam int unsigned TSEL_MSB  = TSEL_LSB + TSW - 1;
  localparam int unsigned STEP_LSB  = ctrl_step_lsb(TSW);
  localparam int unsigned STEP_MSB  = STEP_LSB + SW - 1;
  localparam int unsigned DIR_BIT   = ctrl_dir_bit(TSW, SW);
  localparam int unsigned MODE_LSB  = ctrl_mode_lsb(TSW, SW);
  localparam int unsigned MODE_MSB  = MODE_LSB + 1;

  logic            en_q, en_d;
  logic [TSW-1:0]  tsel_q, tsel_d;
  logic [SW-1:0]   step_q, step_d;
  logic            dir_q, dir_d;
  mode_e           mode_q, mode_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic            tick_q, tick_d;
  logic            lim_q, lim_d;

  logic            fire_c;
  logic [CW:0]     step_ext_c;
  logic [CW:0]     sum_c;
  logic            ovf_c;
  logic [CW-1:0]   bound_c;
  logic [CW-1:0]   nxt_c;
  logic            nxt_lim_c;
  logic            nxt_flip_c;
  logic            unused_wdata_c;

  // Upper write-data bits are not part of any register in this channel.
  assign unused_wdata_c = ^wdata_i;

  // Candidate next value; the extra top bit flags carry/borrow.
  always_comb begin : next_value
    step_ext_c = (CW+1)'(step_q);
    sum_c      = dir_q ? ({1'b0, ctr_q} - step_ext_c) : ({1'b0, ctr_q} + step_ext_c);
    ovf_c      = sum_c[CW];
    bound_c    = dir_q ? '0 : '1;
    nxt_c      = sum_c[CW-1:0];
    nxt_lim_c  = ovf_c;
    nxt_flip_c = 1'b0;
    case (mode_q)
      MODE_SAT: begin
        // A hit only counts when the clamp actually moves the value.
        if (ovf_c) begin
          nxt_c     = bound_c;
          nxt_lim_c = (ctr_q != bound_c);
        end
      end
      MODE_BOUNCE: begin
        if (ovf_c) begin
          nxt_c      = bound_c;
          nxt_lim_c  = 1'b1;
          nxt_flip_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Divider, update and config-write merging.
  always_comb begin : next_state
    en_d      = en_q;
    tsel_d    = tsel_q;
    step_d    = step_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    ctr_d     = ctr_q;
    tick_d    = 1'b0;
    lim_d     = 1'b0;

    fire_c = en_q && strobe_i && (div_cnt_q == div_q);

    if (en_q && strobe_i) begin
      div_cnt_d = fire_c ? '0 : div_cnt_q + DIVW'(1);
    end

    if (fire_c) begin
      ctr_d  = nxt_c;
      dir_d  = dir_q ^ nxt_flip_c;
      tick_d = 1'b1;
      lim_d  = nxt_lim_c;
    end

    // A VALUE write discards the whole update except its tick.
    if (val_we_i) begin
      ctr_d = wdata_i[CW-1:0];
      lim_d = 1'b0;
      dir_d = dir_q;
    end

    // Update above used the old CTRL; the new one lands afterwards.
    if (ctrl_we_i) begin
      en_d   = wdata_i[EN_BIT];
      tsel_d = wdata_i[TSEL_MSB:TSEL_LSB];
      step_d = wdata_i[STEP_MSB:STEP_LSB];
      dir_d  = wdata_i[DIR_BIT];
      mode_d = mode_e'(wdata_i[MODE_MSB:MODE_LSB]);
    end

    if (div_we_i) begin
      div_d     = wdata_i[DIVW-1:0];
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      en_q      <= 1'b0;
      tsel_q    <= '0;
      step_q    <= SW'(1);
      dir_q     <= 1'b0;
      mode_q    <= MODE_WRAP;
      div_q     <= '0;
      div_cnt_q <= '0;
      ctr_q     <= '0;
      tick_q    <= 1'b0;
      lim_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      tsel_q    <= tsel_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      ctr_q     <= ctr_d;
      tick_q    <= tick_d;
      lim_q     <= lim_d;
    end
  end

  assign tsel_o = tsel_q;
  assign ctr_o  = ctr_q;
  assign tick_o = tick_q;
  assign lim_o  = lim_q;

endmodule

// File: rtl/stepped_counter_bank.sv
// stepped_counter_bank: NCH independent stepped counters driven from a shared
// prescaler tap bus, configured at runtime through a small write port.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   taps           one-cycle strobes from the shared prescaler
//   cfg_we         config write strobe
//   cfg_ch         target channel
//   cfg_addr       0=CTRL, 1=DIV, 2=VALUE, 3=reserved
//   cfg_wdata      write data
//   ctr_flat       counter values, channel i at [i*CW +: CW]
//   tick_o, lim_o  per-channel update / limit-event pulses
module stepped_counter_bank
  import stepped_counter_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned CW    = 8,
  parameter  int unsigned SW    = 4,
  parameter  int unsigned NTAPS = 6,
  parameter  int unsigned DIVW  = 8,
  parameter  int unsigned TSW   = 3,
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned WDW   = max3(CW, DIVW, 16)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NTAPS-1:0]    taps,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_addr,
  input  logic [WDW-1:0]      cfg_wdata,
  output logic [NCH*CW-1:0]   ctr_flat,
  output logic [NCH-1:0]      tick_o,
  output logic [NCH-1:0]      lim_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [TSW-1:0] tsel;
    logic           strobe_c;
    logic           sel_c;

    // Tap mux; a select beyond the bus width yields no strobe (stalled).
    always_comb begin : tap_mux
      strobe_c = 1'b0;
      for (int unsigned t = 0; t < NTAPS; t++) begin
        if (tsel == TSW'(t)) strobe_c = taps[t];
      end
    end

    assign sel_c = cfg_we && (cfg_ch == CHW'(g));

    stepped_counter_ch #(
      .CW   (CW),
      .SW   (SW),
      .TSW  (TSW),
      .DIVW (DIVW),
      .WDW  (WDW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .strobe_i  (strobe_c),
      .ctrl_we_i (sel_c && (cfg_addr == ADDR_CTRL)),
      .div_we_i  (sel_c && (cfg_addr == ADDR_DIV)),
      .val_we_i  (sel_c && (cfg_addr == ADDR_VALUE)),
      .wdata_i   (cfg_wdata),
      .tsel_o    (tsel),
      .ctr_o     (ctr_flat[g*CW +: CW]),
      .tick_o    (tick_o[g]),
      .lim_o     (lim_o[g])
    );
  end

endmodule

// File: tb/tb_stepped_counter_bank.sv
`timescale 1ns/1ps
module tb_stepped_counter_bank;

  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int NTAPS = 6;
  localparam int MAXV  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NTAPS-1:0]  taps;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic [NCH*CW-1:0] ctr_flat;
  logic [NCH-1:0]    tick_o;
  logic [NCH-1:0]    lim_o;

  int n_tests = 0;
  int n_fail  = 0;

  stepped_counter_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .taps      (taps),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .ctr_flat  (ctr_flat),
    .tick_o    (tick_o),
    .lim_o     (lim_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integer state per channel.
  int m_en[NCH], m_tsel[NCH], m_step[NCH], m_dir[NCH], m_mode[NCH];
  int m_div[NCH], m_cnt[NCH], m_ctr[NCH], e_tick[NCH], e_lim[NCH];

  always @(posedge clk or negedge rst_n) begin
    int hit, fire, lim, nctr, ndir, v, bound, oor, d;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_tsel[c] = 0; m_step[c] = 1; m_dir[c] = 0; m_mode[c] = 0;
        m_div[c] = 0; m_cnt[c] = 0; m_ctr[c] = 0; e_tick[c] = 0; e_lim[c] = 0;
      end
    end else begin
      d = int'(cfg_wdata);
      for (int c = 0; c < NCH; c++) begin
        hit = 0;
        if (m_tsel[c] < NTAPS) hit = int'(taps[m_tsel[c]]);
        fire = 0; lim = 0; nctr = m_ctr[c]; ndir = m_dir[c];
        if (m_en[c] != 0 && hit != 0) begin
          if (m_cnt[c] == m_div[c]) begin m_cnt[c] = 0; fire = 1; end
          else m_cnt[c] = m_cnt[c] + 1;
        end
        if (fire != 0) begin
          v     = (m_dir[c] != 0) ? m_ctr[c] - m_step[c] : m_ctr[c] + m_step[c];
          bound = (m_dir[c] != 0) ? 0 : MAXV;
          oor   = (v < 0 || v > MAXV) ? 1 : 0;
          case (m_mode[c])
            1: if (oor != 0) begin nctr = bound; lim = (m_ctr[c] != bound) ? 1 : 0; end
               else nctr = v;
            2: if (oor != 0) begin nctr = bound; lim = 1; ndir = 1 - m_dir[c]; end
               else nctr = v;
            default: begin nctr = v & MAXV; lim = oor; end
          endcase
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          case (int'(cfg_addr))
            0: begin
              m_en[c]   = d & 1;
              m_tsel[c] = (d >> 1) & 7;
              m_step[c] = (d >> 4) & 15;
              ndir      = (d >> 8) & 1;
              m_mode[c] = (d >> 9) & 3;
            end
            1: begin m_div[c] = d & 255; m_cnt[c] = 0; end
            2: begin nctr = d & MAXV; lim = 0; ndir = m_dir[c]; end
            default: ;
          endcase
        end
        m_ctr[c] = nctr; m_dir[c] = ndir; e_tick[c] = fire; e_lim[c] = lim;
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int ef, et, el;
    ef = 0; et = 0; el = 0;
    for (int c = 0; c < NCH; c++) begin
      ef = ef | ((m_ctr[c] & MAXV) << (c * CW));
      et = et | (e_tick[c] << c);
      el = el | (e_lim[c] << c);
    end
    chk("model ctr_flat", int'(ctr_flat), ef);
    chk("model tick_o", int'(tick_o), et);
    chk("model lim_o", int'(lim_o), el);
  endtask

  // Drive one cycle of inputs, then check outputs at the following negedge.
  task automatic cyc(int t, int we = 0, int ch = 0, int addr = 0, int data = 0);
    taps      = NTAPS'(t);
    cfg_we    = (we != 0);
    cfg_ch    = 2'(ch);
    cfg_addr  = 2'(addr);
    cfg_wdata = 16'(data);
    @(negedge clk);
    taps   = '0;
    cfg_we = 1'b0;
    compare_model();
  endtask

  function automatic int ctr_of(int c);
    return int'(ctr_flat[c*CW +: CW]);
  endfunction

  initial begin
    int t, dt;
    rst_n = 1'b0; taps = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset ctr_flat", int'(ctr_flat), 0);
    chk("reset tick_o", int'(tick_o), 0);
    chk("reset lim_o", int'(lim_o), 0);
    rst_n = 1'b1;

    // ch0: up, step 3, WRAP, tap0 every 4 clk, from 250
    cyc(0, 1, 0, 0, 'h31);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 2, 250);
    cyc(1);
    chk("wrap first ctr0", ctr_of(0), 253);
    chk("wrap first tick0", int'(tick_o[0]), 1);
    repeat (3) cyc(0);
    chk("wrap idle tick0", int'(tick_o[0]), 0);
    cyc(1);
    chk("wrap carry ctr0", ctr_of(0), 0);
    chk("wrap carry lim0", int'(lim_o[0]), 1);
    repeat (3) cyc(0);

    // ch1: SAT down step 5, div 2, from 7
    cyc(0, 1, 1, 0, 'h353);
    cyc(0, 1, 1, 1, 2);
    cyc(0, 1, 1, 2, 7);
    for (int k = 1; k <= 9; k++) begin
      cyc('b10);
      if (k == 1) chk("sat div tick1", int'(tick_o[1]), 0);
      if (k == 3) chk("sat step ctr1", ctr_of(1), 2);
      if (k == 6) begin
        chk("sat clamp ctr1", ctr_of(1), 0);
        chk("sat clamp lim1", int'(lim_o[1]), 1);
      end
      if (k == 9) begin
        chk("sat hold ctr1", ctr_of(1), 0);
        chk("sat hold lim1", int'(lim_o[1]), 0);
        chk("sat hold tick1", int'(tick_o[1]), 1);
      end
    end

    // ch2: BOUNCE up step 4 from 253
    cyc(0, 1, 2, 0, 'h445);
    cyc(0, 1, 2, 2, 253);
    cyc('b100);
    chk("bounce top ctr2", ctr_of(2), 255);
    chk("bounce top lim2", int'(lim_o[2]), 1);
    cyc('b100);
    chk("bounce back ctr2", ctr_of(2), 251);
    cyc('b100);
    chk("bounce back2 ctr2", ctr_of(2), 247);

    // VALUE write colliding with an update on ch0
    cyc(1, 1, 0, 2, 'h10);
    chk("collide ctr0", ctr_of(0), 'h10);
    chk("collide tick0", int'(tick_o[0]), 1);
    chk("collide lim0", int'(lim_o[0]), 0);
    chk("collide ctr1", ctr_of(1), 0);
    chk("collide ctr2", ctr_of(2), 247);
    chk("collide ctr3", ctr_of(3), 0);

    // Stall via tsel=7, then via en=0, with all taps toggling
    cyc(0, 1, 0, 0, 'h3F);
    repeat (100) begin
      cyc(int'($urandom));
      chk("tsel stall ctr0", ctr_of(0), 'h10);
      chk("tsel stall tick0", int'(tick_o[0]), 0);
    end
    cyc(0, 1, 0, 0, 'h30);
    repeat (100) begin
      cyc(int'($urandom));
      chk("en stall ctr0", ctr_of(0), 'h10);
      chk("en stall tick0", int'(tick_o[0]), 0);
    end
    cyc(0, 1, 0, 0, 'h31);
    cyc(1);
    chk("resume ctr0", ctr_of(0), 'h13);
    chk("resume tick0", int'(tick_o[0]), 1);

    // Asynchronous reset between edges
    repeat (5) cyc(int'($urandom));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst ctr_flat", int'(ctr_flat), 0);
    chk("async rst tick_o", int'(tick_o), 0);
    chk("async rst lim_o", int'(lim_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      cyc('h3F);
      chk("post rst tick_o", int'(tick_o), 0);
    end
    cyc(0, 1, 3, 0, 'h1B);
    cyc('b100000);
    chk("post rst ctr3", ctr_of(3), 1);
    chk("post rst tick3", int'(tick_o[3]), 1);

    // Randomized traffic against the model
    repeat (2000) begin
      t = int'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        int ch, addr;
        ch   = int'($urandom_range(0, NCH - 1));
        addr = int'($urandom_range(0, 3));
        if (addr == 1) dt = int'($urandom_range(0, 3));
        else dt = int'($urandom & 32'hFFFF);
        if (addr == 0 && $urandom_range(0, 3) != 0) dt = dt | 1;
        cyc(t, 1, ch, addr, dt);
      end else begin
        cyc(t);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
